frame_scheduler: RTL

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/npu_pkg.sv | 31 +++
 rtl/frame_scheduler_rr_arbiter.sv | 60 ++++++
 rtl/frame_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : npu_pkg
// Purpose  : Shared defaults, datapath widths and FSM state encoding for the
//            NPU frame scheduling logic.
// Contents : IMG_PIX_DEF / OUT_CNT_DEF / TIMEOUT_DEF frame defaults,
//            RES_W / ADDR_W / PIX_W widths, fsm_state_t scheduler states.
// Revision : 1.0 - initial release
// ============================================================================
package npu_pkg;

  localparam int IMG_PIX_DEF = 1024;  // 32x32 input pixels per frame
  localparam int OUT_CNT_DEF = 225;   // 15x15 pooled results per frame
  localparam int TIMEOUT_DEF = 8192;  // cycles allowed from last pixel to done

  localparam int RES_W  = 22;         // signed extractor result width
  localparam int ADDR_W = 10;         // frame memory read address width
  localparam int PIX_W  = 8;          // pixel width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_START  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERROR  = 3'd6
  } fsm_state_t;

endpackage : npu_pkg
`default_nettype wire

// File: rtl/frame_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Two-way round-robin arbiter. Remembers the requester served most
//            recently and, on a simultaneous request, picks the other one.
// Ports    : clk, rst (async, active-low)
//            req[1:0]   - request vector
//            update     - strobe: record upd_idx as the most recent winner
//            upd_idx    - index of the requester just served
//            choice[1:0]- one-hot winner for the current req (0 if none)
//            choice_idx - index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic [1:0] choice,
  output logic       choice_idx
);

  // Index served most recently. Resetting it to 1 makes requester 0 win the
  // first contested arbitration.
  logic last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= upd_idx;
    end
  end

  always_comb begin
    choice     = 2'b00;
    choice_idx = 1'b0;
    case (req)
      2'b01: begin
        choice     = 2'b01;
        choice_idx = 1'b0;
      end
      2'b10: begin
        choice     = 2'b10;
        choice_idx = 1'b1;
      end
      2'b11: begin
        choice_idx = ~last;
        choice     = last ? 2'b01 : 2'b10;
      end
      default: begin
        choice     = 2'b00;
        choice_idx = 1'b0;
      end
    endcase
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Purpose  : Arbitrates two requesters for a shared feature extractor, streams
//            the winner's frame from its memory into the extractor, forwards
//            the extractor's results tagged with the requester index, and
//            closes each frame with a done or error pulse.
// Ports    : clk, rst (async, active-low)
//            req[1:0]            - level frame requests
//            grant[1:0]          - one-hot grant, held while the frame runs
//            pix_rd_addr[9:0]    - shared frame memory read address
//            pix_rd_data0/1[7:0] - memory data, one cycle after the address
//            fe_start            - one-cycle start pulse to the extractor
//            fe_pixel_valid/fe_pixel[7:0] - pixel stream to the extractor
//            fe_result[21:0], fe_result_valid, fe_done - extractor outputs
//            res_data[21:0], res_valid, res_id, res_last - forwarded results
//            frame_done, frame_err (pulses), busy
// Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler
  import npu_pkg::*;
#(
  parameter int IMG_PIX = IMG_PIX_DEF,
  parameter int OUT_CNT = OUT_CNT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  output logic [1:0]              grant,
  output logic [ADDR_W-1:0]       pix_rd_addr,
  input  logic [PIX_W-1:0]        pix_rd_data0,
  input  logic [PIX_W-1:0]        pix_rd_data1,
  output logic                    fe_start,
  output logic                    fe_pixel_valid,
  output logic [PIX_W-1:0]        fe_pixel,
  input  logic signed [RES_W-1:0] fe_result,
  input  logic                    fe_result_valid,
  input  logic                    fe_done,
  output logic signed [RES_W-1:0] res_data,
  output logic                    res_valid,
  output logic                    res_id,
  output logic                    res_last,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int PCNT_W = $clog2(IMG_PIX + 1);
  localparam int CNT_W  = $clog2(OUT_CNT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(IMG_PIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_PIX - 1);
  localparam logic [CNT_W-1:0]  RES_FULL  = CNT_W'(OUT_CNT);
  localparam logic [CNT_W-1:0]  RES_LIDX  = CNT_W'(OUT_CNT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  fsm_state_t        state;
  fsm_state_t        state_nxt;
  logic [PCNT_W-1:0] pix_cnt;     // valid beats already issued in STREAM
  logic [CNT_W-1:0]  res_cnt;     // results forwarded this frame
  logic              overflow;    // a result arrived after the frame was full
  logic [TMO_W-1:0]  tmo_cnt;     // cycles spent in DRAIN
  logic              gnt_idx;     // index of the requester being served
  logic [1:0]        arb_choice;
  logic              arb_idx;

  logic              in_frame;
  logic              res_take;
  logic              res_drop;
  logic [CNT_W-1:0]  cnt_eff;
  logic              done_ok;

  rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .update     (frame_done | frame_err),
    .upd_idx    (gnt_idx),
    .choice     (arb_choice),
    .choice_idx (arb_idx)
  );

  // Results are only meaningful while a frame is in flight.
  assign in_frame = (state == ST_STREAM) || (state == ST_DRAIN);
  assign res_take = in_frame && fe_result_valid && (res_cnt != RES_FULL);
  assign res_drop = in_frame && fe_result_valid && (res_cnt == RES_FULL);

  // A result arriving together with fe_done is counted before judging the
  // frame, so evaluate completion on the post-update count and overflow.
  assign cnt_eff = res_cnt + CNT_W'(res_take);
  assign done_ok = (cnt_eff == RES_FULL) && !overflow && !res_drop;

  // Moore outputs decoded from the registered state.
  assign fe_start       = (state == ST_START);
  assign fe_pixel_valid = (state == ST_STREAM);
  assign fe_pixel       = fe_pixel_valid ? (gnt_idx ? pix_rd_data1 : pix_rd_data0)
                                         : '0;
  assign frame_done     = (state == ST_FINISH);
  assign frame_err      = (state == ST_ERROR);
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req != 2'b00) state_nxt = ST_ARB;
      // A request withdrawn before arbitration leaves nothing to serve.
      ST_ARB:    state_nxt = (arb_choice != 2'b00) ? ST_START : ST_IDLE;
      ST_START:  state_nxt = ST_STREAM;
      ST_STREAM: if (pix_cnt == PIX_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (fe_done) begin
          state_nxt = done_ok ? ST_FINISH : ST_ERROR;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant       <= 2'b00;
      gnt_idx     <= 1'b0;
      pix_rd_addr <= '0;
      pix_cnt     <= '0;
      res_cnt     <= '0;
      overflow    <= 1'b0;
      tmo_cnt     <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_last    <= 1'b0;
    end else begin
      if (state == ST_ARB && state_nxt == ST_START) begin
        grant   <= arb_choice;
        gnt_idx <= arb_idx;
      end
      if (state_nxt == ST_FINISH || state_nxt == ST_ERROR) begin
        grant <= 2'b00;
      end

      // Address 0 is presented during START; its data becomes the first
      // STREAM beat. The address then runs one ahead of the beat counter and
      // parks on the last address for the final beat.
      case (state)
        ST_START:  pix_rd_addr <= ADDR_W'(1);
        ST_STREAM: if (pix_rd_addr != ADDR_LAST) pix_rd_addr <= pix_rd_addr + ADDR_W'(1);
        default:   pix_rd_addr <= '0;
      endcase

      pix_cnt <= (state == ST_STREAM) ? pix_cnt + PCNT_W'(1) : '0;
      tmo_cnt <= (state == ST_DRAIN)  ? tmo_cnt + TMO_W'(1)  : '0;

      if (state == ST_START) begin
        res_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        if (res_take) res_cnt  <= res_cnt + CNT_W'(1);
        if (res_drop) overflow <= 1'b1;
      end

      res_valid <= res_take;
      res_last  <= res_take && (res_cnt == RES_LIDX);
      res_id    <= res_take && gnt_idx;
      if (res_take) begin
        res_data <= fe_result;
      end
    end
  end

endmodule : frame_scheduler
`default_nettype wire
